parity_frame_checker: RTL and testbench
=======================================

// Module: parity_frame_checker
// PURPOSE
//  Receive end of the 16-input XOR parity generator. Accepts a serial frame of WIDTH data bits, LSB first, then one parity bit.
//  Reassembles the word, checks parity and presents word plus error flag on a valid/ready output port.
//  Sits between the serial link and the word-level consumer. Backpressure is propagated to the serial side.
// PARAMETERS
//  WIDTH    16  data bits per frame (>=2); default matches the generator
//  ODD_PAR  0   0: data^par must be 0 (generator convention, par = XOR of data); 1: must be 1
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  clr          in   1      synchronous flush: abort the frame in progress, drop the held output
//  sin_valid    in   1      serial bit valid
//  sin_ready    out  1      checker can accept a bit this cycle
//  sin_bit      in   1      serial bit
//  out_valid    out  1      word available
//  out_ready    in   1      consumer accepts word
//  out_data     out  WIDTH  reassembled data word
//  out_par_err  out  1      1 = parity mismatch on out_data
//  err_count    out  8      parity-error count; only present with PARITY_ERR_CNT_EN
// BEHAVIOUR
//  - Bit transfer: sin_valid & sin_ready on a rising edge. Word transfer: out_valid & out_ready on a rising edge.
//  - FSM states: S_DATA, S_PAR, S_HOLD.
//  - Reset values: state S_DATA, bit index 0, out_valid 0, out_data 0, out_par_err 0, err_count 0, sin_ready 1.
//  - S_DATA: sin_ready=1. Each transfer writes sin_bit into data[idx] and increments idx.
//    The transfer at idx==WIDTH-1 moves to S_PAR.
//  - S_PAR: sin_ready=1. The transfer computes err = (^data ^ sin_bit) != ODD_PAR.
//    Same edge: out_data<=data, out_par_err<=err, out_valid<=1, next state S_HOLD.
//  - S_HOLD: sin_ready=0. out_* stay stable until a word transfer.
//    On the word transfer: out_valid<=0, idx<=0, next state S_DATA.
//  - Latency: out_valid rises on the cycle after the parity-bit transfer. Frame to frame is WIDTH+1 bit cycles plus 1 hold cycle minimum.
//  - Bubbles: sin_valid=0 mid-frame leaves state and idx unchanged; there is no timeout.
//  - out_ready is ignored while out_valid=0. sin_valid is ignored while sin_ready=0.
//  - clr has priority over every event in the same cycle: state S_DATA, idx 0, out_valid 0. out_data and out_par_err keep their values.
//    err_count is NOT cleared by clr.
//  - rst_n assertion mid-frame or mid-hold returns every register to its reset value immediately (asynchronous). The partial word is lost.
//  - idx is $clog2(WIDTH) bits and never wraps past WIDTH-1.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined:
//   - err_count port exists.
//   - err_count increments by 1 on the S_PAR transfer when err=1.
//   - Saturates at 8'hFF.
//  PARITY_ERR_CNT_EN undefined: no err_count port, no counter logic. All other behaviour is identical.
// STRUCTURE
//  - Shared package parity_pkg:
//    - state typedef {S_DATA,S_PAR,S_HOLD}
//    - localparam PAR_EVEN=0, PAR_ODD=1 (shared with the generator side)
//    - function par_of(data) returning the XOR-reduce of data
//  - One sub-module: parity_deser (shift/index register plus bit counter, asserts done at idx==WIDTH-1).
//    FSM, check logic and output register stay in the top.
// TESTING
//  1. Clean frame: data 16'hA5C3 (XOR=0), par bit 0, out_ready=1 -> out_data=A5C3, out_par_err=0, out_valid for 1 cycle.
//  2. Corrupt frame: 16'h0001 with par bit 0 -> out_par_err=1. With PARITY_ERR_CNT_EN, err_count goes 0->1.
//  3. Backpressure: out_ready=0 for 5 cycles after frame 16'hFFFF/par 0 ->
//     sin_ready=0 and out_* stable throughout; after accept, the next frame is received correctly.
//  4. Bubbles: random sin_valid gaps inside frame 16'h1234 (par 1) -> out_data=1234, err=0.
//  5. Flush/reset: clr after 7 bits, then a full 16'hBEEF frame -> BEEF with correct parity.
//     rst_n pulse mid-frame -> all outputs at reset values.
//  6. Saturation (PARITY_ERR_CNT_EN): 260 bad frames -> err_count holds 8'hFF. ODD_PAR=1 build: 16'hA5C3 with par 1 -> err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared definitions for the parity generator/checker pair
package parity_pkg;

   typedef logic [1:0] state_t;
   localparam state_t S_DATA = 2'd0;
   localparam state_t S_PAR  = 2'd1;
   localparam state_t S_HOLD = 2'd2;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

   // Callers zero-extend narrower words; padding zeros do not change the XOR.
   localparam int PAR_MAX_W = 64;

   function automatic logic par_of(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/parity_deser.sv
// rtl/parity_deser.sv - LSB-first shift/index register; done flags the last data bit
module parity_deser #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rewind,
   input  logic             shift,
   input  logic             bit_in,
   output logic [WIDTH-1:0] data,
   output logic             done
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

   logic [IDX_W-1:0] idx;

   assign done = (idx == LAST);

   // idx parks at LAST until the word is handed off or the frame is flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         data <= '0;
      end else if (rewind) begin
         idx <= '0;
      end else if (shift) begin
         data[idx] <= bit_in;
         if (!done) idx <= idx + 1'b1;
      end
   end

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame receiver with parity check, valid/ready word output
// Optional error counter port err_count enabled by PARITY_ERR_CNT_EN.
module parity_frame_checker
   import parity_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter bit ODD_PAR = PAR_EVEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             sin_valid,
   output logic             sin_ready,
   input  logic             sin_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_par_err
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   state_t           state;
   logic [WIDTH-1:0] data;
   logic             done;
   logic             bit_xfer;
   logic             word_xfer;
   logic             err;

   assign sin_ready = (state != S_HOLD);
   assign bit_xfer  = sin_valid & sin_ready;
   assign word_xfer = out_valid & out_ready;
   assign err       = par_of(PAR_MAX_W'(data)) ^ sin_bit ^ ODD_PAR;

   parity_deser #(.WIDTH(WIDTH)) u_deser (
      .clk    (clk),
      .rst_n  (rst_n),
      .rewind (clr | word_xfer),
      .shift  (bit_xfer & (state == S_DATA) & ~clr),
      .bit_in (sin_bit),
      .data   (data),
      .done   (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_DATA;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_par_err <= 1'b0;
      end else if (clr) begin
         state     <= S_DATA;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_DATA: if (bit_xfer && done) state <= S_PAR;
            S_PAR: begin
               if (bit_xfer) begin
                  out_data    <= data;
                  out_par_err <= err;
                  out_valid   <= 1'b1;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (word_xfer) begin
                  out_valid <= 1'b0;
                  state     <= S_DATA;
               end
            end
            default: state <= S_DATA;
         endcase
      end
   end

`ifdef PARITY_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= 8'h00;
      end else if (!clr && state == S_PAR && bit_xfer && err && err_count != 8'hFF) begin
         err_count <= err_count + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - self-checking bench: vector table, corner sequences, random frames
module tb_parity_frame_checker;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic sin_valid = 1'b0;
   logic sin_bit = 1'b0;
   logic out_ready = 1'b0;
   logic sin_ready, out_valid, out_par_err;
   logic [W-1:0] out_data;
   logic sin_ready_o, out_valid_o, out_par_err_o;
   logic [W-1:0] out_data_o;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0] err_count, err_count_o;
`endif

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;
   int exp_cnt_o = 0;

   always #5 clk = ~clk;

   parity_frame_checker #(.WIDTH(W), .ODD_PAR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .sin_valid(sin_valid), .sin_ready(sin_ready), .sin_bit(sin_bit),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_par_err(out_par_err)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   parity_frame_checker #(.WIDTH(W), .ODD_PAR(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .sin_valid(sin_valid), .sin_ready(sin_ready_o), .sin_bit(sin_bit),
      .out_valid(out_valid_o), .out_ready(out_ready),
      .out_data(out_data_o), .out_par_err(out_par_err_o)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(err_count_o)
`endif
   );

   typedef struct {
      logic [15:0] data;
      logic        par;
      int          hold;
      int          gap;
      logic        err_even;
      logic        err_odd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a frame is in error when the total count of ones disagrees with the polarity.
   function automatic logic model_err(input logic [15:0] d, input logic p, input logic odd);
      return ((($countones(d) + int'(p)) % 2) != int'(odd));
   endfunction

   task automatic send_bit(input logic b, input int max_gap);
      int   gap;
      logic rdy;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      sin_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      sin_valid = 1'b1;
      sin_bit   = b;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         rdy = sin_ready;
         @(posedge clk); #1;
         if (rdy) break;
         if (n == 40) chk("sin_ready_timeout", 32'd0, 32'd1);
      end
      sin_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] d, input logic p, input int max_gap);
      for (int i = 0; i < W; i++) send_bit(d[i], max_gap);
      send_bit(p, max_gap);
   endtask

   task automatic expect_word(input string name, input logic [15:0] d, input logic ee,
                              input logic eo, input int hold);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(d));
      chk({name, "_err"}, 32'(out_par_err), 32'(ee));
      chk({name, "_odd_data"}, 32'(out_data_o), 32'(d));
      chk({name, "_odd_err"}, 32'(out_par_err_o), 32'(eo));
`ifdef PARITY_ERR_CNT_EN
      if (ee && exp_cnt < 255) exp_cnt++;
      if (eo && exp_cnt_o < 255) exp_cnt_o++;
      chk({name, "_cnt"}, 32'(err_count), 32'(exp_cnt));
      chk({name, "_odd_cnt"}, 32'(err_count_o), 32'(exp_cnt_o));
`endif
      out_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         sin_valid = 1'b1;
         sin_bit   = 1'($urandom);
         @(posedge clk); #1;
         chk({name, "_hold_ready"}, 32'(sin_ready), 32'd0);
         chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({name, "_hold_data"}, 32'(out_data), 32'(d));
         chk({name, "_hold_err"}, 32'(out_par_err), 32'(ee));
      end
      sin_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_drop_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_drop_ready"}, 32'(sin_ready), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] d;
      logic        p;

      vecs[0] = '{16'hA5C3, 1'b0, 0, 0, 1'b0, 1'b1};
      vecs[1] = '{16'h0001, 1'b0, 0, 0, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 1'b0, 5, 0, 1'b0, 1'b1};
      vecs[3] = '{16'hA5C3, 1'b1, 0, 0, 1'b1, 1'b0};
      vecs[4] = '{16'h1234, 1'b1, 0, 2, 1'b0, 1'b1};
      vecs[5] = '{16'hBEEF, 1'b1, 0, 0, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_sin_ready", 32'(sin_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_par_err", 32'(out_par_err), 32'd0);
`ifdef PARITY_ERR_CNT_EN
      chk("rst_err_count", 32'(err_count), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].data, vecs[v].par, vecs[v].gap);
         expect_word($sformatf("vec%0d", v), vecs[v].data, vecs[v].err_even,
                     vecs[v].err_odd, vecs[v].hold);
      end

      // Flush after 7 bits, asserted together with a valid bit
      for (int i = 0; i < 7; i++) send_bit(1'($urandom), 0);
      clr = 1'b1;
      sin_valid = 1'b1;
      sin_bit = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      sin_valid = 1'b0;
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_ready", 32'(sin_ready), 32'd1);
      send_frame(16'hBEEF, 1'b1, 0);
      expect_word("after_clr", 16'hBEEF, 1'b0, 1'b1, 0);

      // Flush while holding a word: valid drops, data is retained
      send_frame(16'h00F0, 1'b0, 0);
      chk("hold_clr_pre_valid", 32'(out_valid), 32'd1);
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      chk("hold_clr_valid", 32'(out_valid), 32'd0);
      chk("hold_clr_data", 32'(out_data), 32'h00F0);
      chk("hold_clr_ready", 32'(sin_ready), 32'd1);
`ifdef PARITY_ERR_CNT_EN
      if (exp_cnt_o < 255) exp_cnt_o++;
      chk("hold_clr_cnt", 32'(err_count), 32'(exp_cnt));
      chk("hold_clr_odd_cnt", 32'(err_count_o), 32'(exp_cnt_o));
`endif

      // Asynchronous reset mid-frame after a word with an error was delivered
      send_frame(16'h8001, 1'b1, 0);
      expect_word("pre_rst", 16'h8001, 1'b1, 1'b0, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_data", 32'(out_data), 32'd0);
      chk("arst_err", 32'(out_par_err), 32'd0);
      chk("arst_ready", 32'(sin_ready), 32'd1);
`ifdef PARITY_ERR_CNT_EN
      chk("arst_cnt", 32'(err_count), 32'd0);
`endif
      exp_cnt = 0;
      exp_cnt_o = 0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(16'hBEEF, 1'b1, 0);
      expect_word("after_rst", 16'hBEEF, 1'b0, 1'b1, 0);

      for (int r = 0; r < 40; r++) begin
         d = 16'($urandom);
         p = 1'($urandom);
         send_frame(d, p, int'($urandom_range(1, 0)));
         expect_word($sformatf("rnd%0d", r), d, model_err(d, p, 1'b0), model_err(d, p, 1'b1),
                     int'($urandom_range(3, 0)));
      end

`ifdef PARITY_ERR_CNT_EN
      for (int s = 0; s < 260; s++) begin
         send_frame(16'h0001, 1'b0, 0);
         expect_word("sat", 16'h0001, 1'b1, 1'b0, 0);
      end
      chk("sat_final", 32'(err_count), 32'hFF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
